// File: rtl/demux_1_26_collector.sv
// Scatters tagged single-bit beats into an N-slot vector and presents the
// completed vector on a valid/ready port once every slot has been written.
module demux_1_26_collector #(
   parameter int unsigned N     = 26,
   parameter int unsigned SEL_W = 8,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic [SEL_W-1:0] in_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:N-1]     out_set,
   output logic [CNT_W-1:0] fill_count,
   output logic             sel_err
);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t           r_state;
   logic [0:N-1]     r_set;
   logic [0:N-1]     r_written;
   logic [CNT_W-1:0] r_count;
   logic             r_sel_err;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [0:N-1]     w_onehot;
   logic [0:N-1]     w_written_nxt;
   logic             w_in_range;
   logic             w_new_slot;

   assign w_in_range    = (in_select < SEL_W'(N));
   assign w_written_nxt = r_written | w_onehot;
   assign w_new_slot    = |(w_onehot & ~r_written);

   always_comb begin
      w_onehot = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (in_select == SEL_W'(k)) w_onehot[k] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= COLLECT;
         r_set       <= '0;
         r_written   <= '0;
         r_count     <= '0;
         r_sel_err   <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_sel_err <= 1'b0;
         case (r_state)
            COLLECT: begin
               if (in_valid) begin
                  if (w_in_range) begin
                     for (int unsigned k = 0; k < N; k++) begin
                        if (w_onehot[k]) r_set[k] <= in_bit;
                     end
                     r_written <= w_written_nxt;
                     if (w_new_slot) r_count <= r_count + CNT_W'(1);
                     // Frame closes on the beat that fills the last empty slot.
                     if (&w_written_nxt) begin
                        r_state     <= HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                     end
                  end else begin
                     r_sel_err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= COLLECT;
                  r_written   <= '0;
                  r_count     <= '0;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_set    = r_set;
   assign fill_count = r_count;
   assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_demux_1_26_collector.sv
// Directed-vector bench for demux_1_26_collector with hand-computed expectations.
module tb_demux_1_26_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_bit;
   logic [7:0]  in_select;
   logic        out_valid;
   logic        out_ready;
   logic [0:25] out_set;
   logic [4:0]  fill_count;
   logic        sel_err;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_selerr;
   int unsigned n_valid;
   int unsigned n_notready;
   logic [25:0] held;

   demux_1_26_collector #(.N(26), .SEL_W(8), .CNT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bit     (in_bit),
      .in_select  (in_select),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_set    (out_set),
      .fill_count (fill_count),
      .sel_err    (sel_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      n_selerr   += 32'(sel_err);
      n_valid    += 32'(out_valid);
      n_notready += 32'(!in_ready);
   endtask

   task automatic beat(input logic b, input logic [7:0] sel);
      in_valid  = 1'b1;
      in_bit    = b;
      in_select = sel;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_select = '0; out_ready = 1'b0;
      n_selerr = 0; n_valid = 0; n_notready = 0;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      check_val("rst_in_ready",  32'(in_ready),   32'd1);
      check_val("rst_out_valid", 32'(out_valid),  32'd0);
      check_val("rst_fill",      32'(fill_count), 32'd0);
      check_val("rst_out_set",   32'(out_set),    32'h0);

      // Ascending frame, bit = index[0]
      for (int k = 0; k < 26; k++) begin
         beat(1'(k & 1), 8'(k));
         if (k == 24) begin
            check_val("f1_valid_before_last", 32'(out_valid),  32'd0);
            check_val("f1_fill_25",           32'(fill_count), 32'd25);
         end
      end
      check_val("f1_out_valid", 32'(out_valid),  32'd1);
      check_val("f1_out_set",   32'(out_set),    32'h1555555);
      check_val("f1_fill",      32'(fill_count), 32'd26);
      check_val("f1_in_ready",  32'(in_ready),   32'd0);
      consume();
      check_val("f1_cons_valid", 32'(out_valid),  32'd0);
      check_val("f1_cons_ready", 32'(in_ready),   32'd1);
      check_val("f1_cons_fill",  32'(fill_count), 32'd0);

      // Descending frame with duplicate slot 7 and out-of-range index 30
      n_selerr = 0;
      for (int k = 25; k >= 8; k--) beat(1'b1, 8'(k));
      check_val("f2_selerr_idle", 32'(sel_err), 32'd0);
      beat(1'b1, 8'd30);
      check_val("f2_selerr_pulse", 32'(sel_err),    32'd1);
      check_val("f2_fill_after30", 32'(fill_count), 32'd18);
      beat(1'b0, 8'd7);
      check_val("f2_selerr_clear", 32'(sel_err),    32'd0);
      check_val("f2_fill_7a",      32'(fill_count), 32'd19);
      beat(1'b1, 8'd7);
      check_val("f2_fill_7b", 32'(fill_count), 32'd19);
      for (int k = 6; k >= 0; k--) beat(1'b1, 8'(k));
      check_val("f2_fill",      32'(fill_count), 32'd26);
      check_val("f2_out_valid", 32'(out_valid),  32'd1);
      check_val("f2_out_set",   32'(out_set),    32'h3FFFFFF);
      check_val("f2_slot7",     32'(out_set[7]), 32'd1);
      held = out_set;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_bit = 1'b0; in_select = 8'(k);
         tick();
         check_val("f2_hold_set",   32'(out_set),    32'(held));
         check_val("f2_hold_valid", 32'(out_valid),  32'd1);
         check_val("f2_hold_fill",  32'(fill_count), 32'd26);
      end
      in_valid = 1'b0;
      check_val("f2_selerr_count", n_selerr, 32'd1);
      consume();

      // Zero frame, consume, then partial frame of 25 slots
      for (int k = 0; k < 26; k++) beat(1'b0, 8'(k));
      check_val("f3_out_set", 32'(out_set), 32'h0);
      consume();
      for (int k = 0; k < 25; k++) beat(1'b1, 8'(k));
      check_val("f3_partial_valid", 32'(out_valid),  32'd0);
      check_val("f3_partial_fill",  32'(fill_count), 32'd25);
      check_val("f3_partial_ready", 32'(in_ready),   32'd1);
      beat(1'b1, 8'd25);
      check_val("f3_last_valid", 32'(out_valid), 32'd1);
      check_val("f3_last_set",   32'(out_set),   32'h3FFFFFF);
      consume();

      // Reset mid-frame with a concurrent beat
      for (int k = 0; k < 13; k++) beat(1'b1, 8'(k));
      check_val("f4_fill_13", 32'(fill_count), 32'd13);
      rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_select = 8'd13;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check_val("f4_rst_fill",  32'(fill_count), 32'd0);
      check_val("f4_rst_set",   32'(out_set),    32'h0);
      check_val("f4_rst_valid", 32'(out_valid),  32'd0);
      for (int k = 0; k < 26; k++) beat(1'((k & 1) == 0), 8'(k));
      check_val("f4_frame_valid", 32'(out_valid), 32'd1);
      check_val("f4_frame_set",   32'(out_set),   32'h2AAAAAA);
      consume();

      // Back-to-back frames with out_ready tied high
      out_ready = 1'b1; n_valid = 0; n_notready = 0;
      for (int k = 0; k < 26; k++) beat(1'b1, 8'(k));
      check_val("bb1_valid", 32'(out_valid), 32'd1);
      check_val("bb1_set",   32'(out_set),   32'h3FFFFFF);
      beat(1'b0, 8'd0);
      check_val("bb_gap_ready", 32'(in_ready),   32'd1);
      check_val("bb_gap_fill",  32'(fill_count), 32'd0);
      for (int k = 0; k < 26; k++) beat(1'b0, 8'(k));
      check_val("bb2_valid", 32'(out_valid), 32'd1);
      check_val("bb2_set",   32'(out_set),   32'h0);
      tick();
      check_val("bb2_drop",          32'(out_valid), 32'd0);
      check_val("bb_valid_cycles",   n_valid,        32'd2);
      check_val("bb_notready_cycles", n_notready,    32'd2);
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/demux_1_26_collector.md
Name: demux_1_26_collector

Overview:
- Inverse of the 26:1 bit-select mux used in the accelerator datapath.
- Accepts a stream of single bits, each tagged with an 8-bit index, and scatters each bit into slot `set[index]` of a 26-entry register vector.
- When all 26 slots have been written at least once, presents the assembled vector on a valid/ready output port and holds it until it is consumed.
- Feeds packed 26-bit vectors back into the mux-side logic.

Parameters:
- N, 26, number of slots in the output vector (ascending range 0..N-1).
- SEL_W, 8, width of the index/select input.
- CNT_W, 5, width of fill_count; must satisfy 2^CNT_W > N.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  collector can accept a beat.
- in_bit  input  1  data bit to write.
- in_select  input  SEL_W  target slot index.
- out_valid  output  1  assembled vector available.
- out_ready  input  1  downstream consumes vector.
- out_set  output  [0:N-1]  assembled vector; out_set[k] is the last bit written to index k.
- fill_count  output  CNT_W  number of distinct slots written in the current frame.
- sel_err  output  1  one-cycle pulse: an accepted beat had in_select >= N.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high: `rst` is sampled on the rising edge of `clk`.
  - `rst` high at a clock edge forces the following, and overrides any concurrent handshake:
    - state = COLLECT
    - out_set = 0
    - written mask = 0
    - fill_count = 0
    - out_valid = 0
    - sel_err = 0
  - Reset mid-frame or in HOLD discards all partial or held data.
- Internal state:
  - `set_q[0:N-1]`: data register driving out_set.
  - `written[0:N-1]`: mask of slots written in the current frame.
  - FSM with states COLLECT and HOLD.
- Ready/valid decode:
  - in_ready = 1 in COLLECT, 0 in HOLD. Decoded from the state register only; no combinational path from any input.
  - out_valid = 1 in HOLD, 0 in COLLECT. Registered.
  - Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- COLLECT, on input accept with in_select < N:
  - `set_q[in_select] <= in_bit`.
  - `written[in_select] <= 1`.
  - If the slot was not already written, fill_count increments by 1.
  - Rewriting an already-written slot overwrites its data bit; fill_count is unchanged.
- COLLECT, on input accept with in_select >= N (values 26..255):
  - No write; mask and count are unchanged.
  - sel_err = 1 on the next cycle for exactly one cycle.
  - The beat is still consumed (in_ready stays 1).
- COLLECT → HOLD:
  - Taken at the edge where the accepted beat makes written all-ones (fill_count reaches N).
  - out_valid rises on the cycle after that beat: one cycle of latency from the last write.
  - out_set then shows the complete vector, fill_count = N.
- HOLD:
  - out_set is stable and in_ready = 0; input beats are not accepted and have no effect.
  - Output accept → state = COLLECT, written = 0, fill_count = 0, out_valid = 0, all at the same edge.
  - set_q retains its values; out_set is meaningful only while out_valid = 1.
  - in_ready returns to 1 on the cycle after the output accept. Minimum frame-to-frame spacing is therefore N accepted beats + 1 HOLD cycle.
- out_ready:
  - Ignored while out_valid = 0.
  - out_ready held high continuously gives a one-cycle HOLD.
- Index width: in_select is compared as unsigned SEL_W bits; no truncation or modulo mapping.
- Arithmetic:
  - fill_count never exceeds N.
  - No wrap: the count is cleared only by output accept or reset.

Test Plan:
- Reset, then in_valid = 0 for 5 cycles → in_ready = 1, out_valid = 0, fill_count = 0, out_set = 0.
- Write indices 0..25 in order with in_bit = index[0] (alternating 0,1) → out_valid rises the cycle after index 25. out_set[0:25] = 0101…01 (set[k] = k&1), fill_count = 26, in_ready = 0.
- Write indices 25 down to 0 with bit = 1, but write index 7 twice (0 then 1) and index 30 once, out_ready held low for 10 cycles:
  - fill_count = 26, not 27.
  - out_set[7] = 1.
  - sel_err pulses once, for 1 cycle, after the index-30 beat.
  - out_set stays stable for all 10 HOLD cycles.
  - Beats driven with in_valid = 1 during HOLD have no effect.
- Complete a frame, assert out_ready for one cycle, then write indices 0..24 only → out_valid = 0, fill_count = 25. Writing index 25 then raises out_valid on the following cycle.
- Write 13 beats, assert rst for one cycle while in_valid = 1 → next cycle: fill_count = 0, out_set = 0. A full 26-beat frame afterwards completes normally.
- Back-to-back frames with out_ready tied high, two frames of all-ones then all-zeros:
  - Each frame produces exactly one out_valid cycle with the correct vector.
  - in_ready is low for exactly one cycle between the frames.
